elm_output_layer: RTL and testbench

- Downstream stage of the hidden-layer datapath (DATAPATHM1) in the binary-input Extreme Learning Machine.
- Consumes each hidden-neuron pre-activation (OUT, qualified by done256, indexed by P_index, final neuron flagged by stop), applies a saturating ReLU and multiply-accumulates it against N_CLASS signed output weights read from a combinational-read weight memory.
- After the last neuron, performs an argmax over the class accumulators and reports the winning class.

---
 rtl/elm_pkg.sv | 23 ++
 rtl/elm_relu_clip.sv | 30 +++
 rtl/elm_output_layer.sv | 188 ++++++++++++++++++
 tb/tb_elm_output_layer.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elm_pkg.sv
// Shared widths, defaults and FSM encoding for the ELM output-layer datapath.
package elm_pkg;

   localparam int ELM_ACC_W     = 16;
   localparam int ELM_P_W       = 13;
   localparam int ELM_N_CLASS   = 10;
   localparam int ELM_W_W       = 8;
   localparam int ELM_ACT_SHIFT = 4;
   localparam int ELM_OACC_W    = 32;

   localparam int         ACT_W   = 8;
   localparam logic [7:0] ACT_MAX = 8'd255;
   localparam int         CLS_W   = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_MAC,
      ST_ARGMAX,
      ST_DONE
   } elm_state_t;

endpackage : elm_pkg

// File: rtl/elm_relu_clip.sv
// Saturating ReLU: arithmetic right shift, then clip the result into an unsigned 8-bit activation.
module elm_relu_clip
   import elm_pkg::*;
#(
   parameter int ACC_W     = ELM_ACC_W,
   parameter int ACT_SHIFT = ELM_ACT_SHIFT
) (
   input  logic signed [ACC_W-1:0] i_value,
   output logic        [ACT_W-1:0] o_act
);

   localparam logic signed [ACC_W-1:0] CLIP_HI = ACC_W'(ACT_MAX);

   logic signed [ACC_W-1:0] w_shifted;

   assign w_shifted = i_value >>> ACT_SHIFT;

   always_comb begin
      // NOTE: default first so every path assigns o_act and no latch is inferred.
      o_act = '0;
      if (w_shifted[ACC_W-1]) begin
         o_act = '0;
      end else if (w_shifted > CLIP_HI) begin
         o_act = ACT_MAX;
      end else begin
         o_act = w_shifted[ACT_W-1:0];
      end
   end

endmodule : elm_relu_clip

// File: rtl/elm_output_layer.sv
// ELM output layer: buffers hidden-neuron values, MACs ReLU activations against class weights,
// then runs a sequential argmax and reports the winning class and its score.
module elm_output_layer
   import elm_pkg::*;
#(
   parameter int ACC_W     = ELM_ACC_W,
   parameter int P_W       = ELM_P_W,
   parameter int N_CLASS   = ELM_N_CLASS,
   parameter int W_W       = ELM_W_W,
   parameter int ACT_SHIFT = ELM_ACT_SHIFT,
   parameter int OACC_W    = ELM_OACC_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              hid_valid,
   input  logic [ACC_W-1:0]  hid_value,
   input  logic [P_W-1:0]    hid_index,
   input  logic              hid_last,
   output logic [P_W+3:0]    w_addr,
   input  logic [W_W-1:0]    w_data,
   output logic              busy,
   output logic              result_valid,
   output logic [CLS_W-1:0]  result_class,
   output logic [OACC_W-1:0] result_score,
   output logic              overrun
);

   localparam int ADDR_W = P_W + 4;
   localparam int PROD_W = W_W + ACT_W + 1;

   elm_state_t r_state;

   logic              r_hold_full;
   logic [ACC_W-1:0]  r_hold_value;
   logic [P_W-1:0]    r_hold_index;
   logic              r_hold_last;
   logic              r_overrun;

   logic [ACC_W-1:0]  r_value;
   logic              r_last;
   logic [ADDR_W-1:0] r_base;
   logic [ACT_W-1:0]  r_act;
   logic [CLS_W-1:0]  r_k;
   logic [ADDR_W-1:0] r_w_addr;

   logic signed [OACC_W-1:0] r_acc [N_CLASS];
   logic [CLS_W-1:0]         r_best_idx;
   logic signed [OACC_W-1:0] r_best_val;

   logic              r_result_valid;
   logic [CLS_W-1:0]  r_result_class;
   logic [OACC_W-1:0] r_result_score;

   logic                     w_leave_idle;
   logic                     w_accept;
   logic [ACT_W-1:0]         w_act;
   logic signed [PROD_W-1:0] w_prod;
   logic signed [OACC_W-1:0] w_prod_ext;
   logic                     w_k_last;
   logic signed [OACC_W-1:0] w_acc_k;
   logic                     w_take;
   logic [ADDR_W-1:0]        w_base_next;

   elm_relu_clip #(
      .ACC_W     (ACC_W),
      .ACT_SHIFT (ACT_SHIFT)
   ) u_relu_clip (
      .i_value (r_value),
      .o_act   (w_act)
   );

   // The hold slot empties on the same edge the FSM copies it out, so a new sample may land there too.
   assign w_leave_idle = (r_state == ST_IDLE) && r_hold_full;
   assign w_accept     = hid_valid && (!r_hold_full || w_leave_idle);

   assign w_prod      = $signed({1'b0, r_act}) * $signed(w_data);
   assign w_prod_ext  = {{(OACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
   assign w_k_last    = (r_k == CLS_W'(N_CLASS - 1));
   assign w_acc_k     = r_acc[r_k];
   assign w_take      = (r_k == '0) || (w_acc_k > r_best_val);
   assign w_base_next = ADDR_W'(r_hold_index) * ADDR_W'(N_CLASS);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hold_full <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every register update on the same edge, order-independent.
         if (w_accept) begin
            r_hold_full <= 1'b1;
         end else if (w_leave_idle) begin
            r_hold_full <= 1'b0;
         end
         if (hid_valid && !w_accept) begin
            r_overrun <= 1'b1;
         end
      end
   end

   // NOTE: payload registers carry no reset; r_hold_full alone says whether they are meaningful.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_hold_value <= hid_value;
         r_hold_index <= hid_index;
         r_hold_last  <= hid_last;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= ST_IDLE;
         r_value        <= '0;
         r_last         <= 1'b0;
         r_base         <= '0;
         r_act          <= '0;
         r_k            <= '0;
         r_w_addr       <= '0;
         r_best_idx     <= '0;
         r_best_val     <= '0;
         r_result_valid <= 1'b0;
         r_result_class <= '0;
         r_result_score <= '0;
         // NOTE: the accumulator array is reset because an aborted run must not leak into the next result.
         for (int i = 0; i < N_CLASS; i++) begin
            r_acc[i] <= '0;
         end
      end else begin
         r_result_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (r_hold_full) begin
                  r_value <= r_hold_value;
                  r_last  <= r_hold_last;
                  r_base  <= w_base_next;
                  r_state <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               r_act    <= w_act;
               r_k      <= '0;
               r_w_addr <= r_base;
               r_state  <= ST_MAC;
            end
            ST_MAC: begin
               r_acc[r_k] <= w_acc_k + w_prod_ext;
               if (w_k_last) begin
                  r_k     <= '0;
                  r_state <= r_last ? ST_ARGMAX : ST_IDLE;
               end else begin
                  r_k      <= r_k + 1'b1;
                  r_w_addr <= r_base + ADDR_W'(r_k) + 1'b1;
               end
            end
            ST_ARGMAX: begin
               // Strict greater-than keeps the lowest index on ties.
               if (w_take) begin
                  r_best_idx <= r_k;
                  r_best_val <= w_acc_k;
               end
               if (w_k_last) begin
                  r_result_valid <= 1'b1;
                  r_result_class <= w_take ? r_k : r_best_idx;
                  r_result_score <= w_take ? w_acc_k : r_best_val;
                  r_k            <= '0;
                  r_state        <= ST_DONE;
               end else begin
                  r_k <= r_k + 1'b1;
               end
            end
            ST_DONE: begin
               for (int i = 0; i < N_CLASS; i++) begin
                  r_acc[i] <= '0;
               end
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign w_addr       = r_w_addr;
   assign busy         = (r_state != ST_IDLE) || r_hold_full;
   assign result_valid = r_result_valid;
   assign result_class = r_result_class;
   assign result_score = r_result_score;
   assign overrun      = r_overrun;

endmodule : elm_output_layer

// File: tb/tb_elm_output_layer.sv
// Scoreboard bench for elm_output_layer: a behavioural model pushes expected results,
// and each scenario task pops and compares them when result_valid fires.
module tb_elm_output_layer;

   localparam int N = 10;

   typedef struct packed {
      logic [3:0]  cls;
      logic [31:0] score;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        hid_valid;
   logic [15:0] hid_value;
   logic [12:0] hid_index;
   logic        hid_last;
   logic [16:0] w_addr;
   logic [7:0]  w_data;
   logic        busy;
   logic        result_valid;
   logic [3:0]  result_class;
   logic [31:0] result_score;
   logic        overrun;

   logic signed [7:0] mem [0:255];
   exp_t              sb [$];
   int                m_acc [N];
   int                tests_run;
   int                tests_failed;

   elm_output_layer dut (
      .clk          (clk),
      .rst          (rst),
      .hid_valid    (hid_valid),
      .hid_value    (hid_value),
      .hid_index    (hid_index),
      .hid_last     (hid_last),
      .w_addr       (w_addr),
      .w_data       (w_data),
      .busy         (busy),
      .result_valid (result_valid),
      .result_class (result_class),
      .result_score (result_score),
      .overrun      (overrun)
   );

   assign w_data = mem[w_addr[7:0]];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int model_act(input logic [15:0] v);
      int s;
      s = int'($signed(v)) >>> 4;
      if (s < 0) return 0;
      if (s > 255) return 255;
      return s;
   endfunction

   task automatic model_clear();
      for (int k = 0; k < N; k++) m_acc[k] = 0;
   endtask

   task automatic model_add(input logic [15:0] v, input int idx);
      for (int k = 0; k < N; k++) m_acc[k] += model_act(v) * int'(mem[idx*N + k]);
   endtask

   task automatic model_push();
      exp_t e;
      int   best;
      best = 0;
      for (int k = 1; k < N; k++) if (m_acc[k] > m_acc[best]) best = k;
      e.cls   = 4'(best);
      e.score = 32'(m_acc[best]);
      sb.push_back(e);
      model_clear();
   endtask

   task automatic fill_mem(input logic signed [7:0] v);
      for (int i = 0; i < 256; i++) mem[i] = v;
   endtask

   task automatic do_reset();
      @(negedge clk) rst = 1'b1;
      @(negedge clk);
      @(negedge clk) rst = 1'b0;
      model_clear();
   endtask

   task automatic send(input logic [15:0] v, input logic [12:0] idx, input logic last);
      @(negedge clk);
      hid_valid = 1'b1;
      hid_value = v;
      hid_index = idx;
      hid_last  = last;
      @(negedge clk);
      hid_valid = 1'b0;
   endtask

   task automatic wait_result(input int max_cycles, output bit got, output int cycles, output exp_t obs);
      got    = 1'b0;
      cycles = 0;
      obs    = '0;
      for (int n = 1; n <= max_cycles; n++) begin
         @(negedge clk);
         if (result_valid) begin
            got       = 1'b1;
            cycles    = n;
            obs.cls   = result_class;
            obs.score = result_score;
            break;
         end
      end
   endtask

   task automatic test_reset();
      bit   got;
      int   cyc;
      int   spurious;
      exp_t obs;
      exp_t e;
      do_reset();
      tests_run++;
      if ({busy, result_valid, result_class, result_score, overrun, w_addr} !== '0) begin
         tests_failed++;
         $display("FAIL reset_init: busy=%b rv=%b cls=%0d score=%0d ovr=%b addr=%0d required all 0",
                  busy, result_valid, result_class, result_score, overrun, w_addr);
      end
      fill_mem(8'sd7);
      send(16'h1000, 13'd0, 1'b1);
      repeat (4) @(negedge clk);
      tests_run++;
      if (busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_busy_mid: busy=%b required 1", busy);
      end
      do_reset();
      tests_run++;
      if ({busy, result_valid, result_class, result_score, overrun, w_addr} !== '0) begin
         tests_failed++;
         $display("FAIL reset_abort: busy=%b rv=%b cls=%0d score=%0d ovr=%b addr=%0d required all 0",
                  busy, result_valid, result_class, result_score, overrun, w_addr);
      end
      spurious = 0;
      repeat (40) begin
         @(negedge clk);
         if (result_valid) spurious++;
      end
      tests_run++;
      if (spurious != 0) begin
         tests_failed++;
         $display("FAIL reset_no_result: saw %0d result_valid pulses, required 0", spurious);
      end
      for (int k = 0; k < N; k++) mem[k] = 8'(k);
      send(16'h0100, 13'd0, 1'b1);
      model_add(16'h0100, 0);
      model_push();
      wait_result(60, got, cyc, obs);
      e = sb.pop_front();
      tests_run++;
      if (!got || obs !== e) begin
         tests_failed++;
         $display("FAIL reset_rerun: got=%b cls=%0d score=%0d required cls=%0d score=%0d",
                  got, obs.cls, obs.score, e.cls, e.score);
      end
   endtask

   task automatic test_single();
      bit   got;
      int   cyc;
      exp_t obs;
      exp_t e;
      do_reset();
      for (int k = 0; k < N; k++) mem[k] = 8'(k);
      send(16'h0100, 13'd0, 1'b1);
      model_add(16'h0100, 0);
      model_push();
      wait_result(60, got, cyc, obs);
      e = sb.pop_front();
      tests_run++;
      if (!got || cyc != 22) begin
         tests_failed++;
         $display("FAIL single_latency: got=%b cycles=%0d required 22", got, cyc);
      end
      tests_run++;
      if (obs !== e || obs.cls !== 4'd9 || obs.score !== 32'd144) begin
         tests_failed++;
         $display("FAIL single_result: cls=%0d score=%0d required cls=9 score=144", obs.cls, obs.score);
      end
      @(negedge clk);
      tests_run++;
      if (result_valid !== 1'b0 || result_class !== 4'd9 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL single_hold: rv=%b cls=%0d busy=%b required rv=0 cls=9 busy=0",
                  result_valid, result_class, busy);
      end
   endtask

   task automatic test_clip();
      bit   got;
      int   cyc;
      exp_t obs;
      exp_t e;
      do_reset();
      fill_mem(-8'sd128);
      send(16'h7FFF, 13'd0, 1'b0);
      model_add(16'h7FFF, 0);
      repeat (15) @(negedge clk);
      send(16'hFF00, 13'd1, 1'b1);
      model_add(16'hFF00, 1);
      model_push();
      wait_result(60, got, cyc, obs);
      e = sb.pop_front();
      tests_run++;
      if (!got || obs !== e || obs.score !== 32'hFFFF_8080 || obs.cls !== 4'd0) begin
         tests_failed++;
         $display("FAIL clip: got=%b cls=%0d score=%0d required cls=0 score=-32640",
                  got, obs.cls, $signed(obs.score));
      end
   endtask

   task automatic test_two_neurons();
      bit          got;
      int          cyc;
      exp_t        obs;
      exp_t        e;
      logic [16:0] addr_log [$];
      logic [16:0] prev;
      int          bad;
      do_reset();
      fill_mem(8'sd0);
      mem[3]  = 8'sd5;
      mem[7]  = 8'sd1;
      mem[13] = -8'sd5;
      mem[17] = 8'sd1;
      fork
         begin
            prev = w_addr;
            repeat (70) begin
               @(negedge clk);
               if (w_addr !== prev) begin
                  addr_log.push_back(w_addr);
                  prev = w_addr;
               end
            end
         end
         begin
            send(16'h00A0, 13'd0, 1'b0);
            model_add(16'h00A0, 0);
            repeat (15) @(negedge clk);
            send(16'h00A0, 13'd1, 1'b1);
            model_add(16'h00A0, 1);
            model_push();
            wait_result(60, got, cyc, obs);
         end
      join
      e = sb.pop_front();
      tests_run++;
      if (!got || obs !== e || obs.cls !== 4'd7 || obs.score !== 32'd20) begin
         tests_failed++;
         $display("FAIL two_neurons: got=%b cls=%0d score=%0d required cls=7 score=20",
                  got, obs.cls, obs.score);
      end
      bad = 0;
      if (addr_log.size() != 19) bad = 1;
      else for (int i = 0; i < 19; i++) if (addr_log[i] !== 17'(i + 1)) bad = 1;
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("FAIL w_addr_seq: %0d address changes, required 1..19 in order", addr_log.size());
      end
   endtask

   task automatic test_tie();
      bit   got;
      int   cyc;
      exp_t obs;
      exp_t e;
      do_reset();
      fill_mem(8'sd3);
      send(16'h0010, 13'd0, 1'b1);
      model_add(16'h0010, 0);
      model_push();
      wait_result(60, got, cyc, obs);
      e = sb.pop_front();
      tests_run++;
      if (!got || obs !== e || obs.cls !== 4'd0 || obs.score !== 32'd3) begin
         tests_failed++;
         $display("FAIL tie: got=%b cls=%0d score=%0d required cls=0 score=3", got, obs.cls, obs.score);
      end
   endtask

   task automatic test_overrun();
      bit   got;
      int   cyc;
      int   extra;
      exp_t obs;
      exp_t e;
      do_reset();
      fill_mem(8'sd1);
      for (int k = 0; k < N; k++) mem[k] = 8'(k + 1);
      mem[12] = 8'sd50;
      mem[25] = 8'sd100;
      @(negedge clk);
      hid_valid = 1'b1; hid_value = 16'h0050; hid_index = 13'd0; hid_last = 1'b0;
      @(negedge clk);
      hid_value = 16'h0030; hid_index = 13'd1; hid_last = 1'b1;
      @(negedge clk);
      hid_value = 16'h0100; hid_index = 13'd2; hid_last = 1'b1;
      @(negedge clk);
      hid_valid = 1'b0;
      model_add(16'h0050, 0);
      model_add(16'h0030, 1);
      model_push();
      tests_run++;
      if (overrun !== 1'b1) begin
         tests_failed++;
         $display("FAIL overrun_set: overrun=%b required 1", overrun);
      end
      wait_result(100, got, cyc, obs);
      e = sb.pop_front();
      tests_run++;
      if (!got || obs !== e) begin
         tests_failed++;
         $display("FAIL overrun_result: got=%b cls=%0d score=%0d required cls=%0d score=%0d",
                  got, obs.cls, obs.score, e.cls, e.score);
      end
      extra = 0;
      repeat (40) begin
         @(negedge clk);
         if (result_valid) extra++;
      end
      tests_run++;
      if (extra != 0 || overrun !== 1'b1 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL overrun_sticky: extra=%0d overrun=%b busy=%b required 0/1/0", extra, overrun, busy);
      end
      do_reset();
      tests_run++;
      if (overrun !== 1'b0) begin
         tests_failed++;
         $display("FAIL overrun_clear: overrun=%b required 0", overrun);
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst          = 1'b1;
      hid_valid    = 1'b0;
      hid_value    = '0;
      hid_index    = '0;
      hid_last     = 1'b0;
      fill_mem(8'sd0);
      model_clear();
      test_reset();
      test_single();
      test_clip();
      test_two_neurons();
      test_tie();
      test_overrun();
      tests_run++;
      if (sb.size() != 0) begin
         tests_failed++;
         $display("FAIL scoreboard_empty: %0d entries left, required 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_elm_output_layer
